// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage.
//   common : basic scalar types (raw instruction word, datapath word, register address)
//   pipes  : control bundle, op/alu enumerations, RISC-V opcode/funct constants,
//            memory access size encodings and immediate format selector.
package common;
  typedef logic [31:0] u32;
  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;
endpackage

package pipes;
  // OP_NOP must stay at zero so an all-zero control bundle reads as a NOP.
  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW, OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_UNKNOWN
  } op_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alufunc_t;

  typedef struct packed {
    op_t        op;
    alufunc_t   alufunc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] memsize;
    logic       memunsigned;
    logic       is_branch;
    logic       is_jump;
    logic       use_rs1;
    logic       use_rs2;
    logic       is_word;
    logic       illegal;
  } control_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SRL = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_SRA = 7'b0100000;
endpackage

// File: rtl/decode_stage_decode_comb.sv
// decode_comb: purely combinational RV32I/RV64I instruction decoder.
// Ports:
//   instr : raw 32-bit instruction
//   ctl   : control bundle (op, alu function, memory/branch/jump flags, illegal)
//   rs1/rs2/rd : register fields, zeroed when the format does not use them
//   imm   : sign-extended immediate of the instruction's format
module decode_comb
  import common::*;
  import pipes::*;
#(
  parameter int XLEN        = 64,
  parameter bit EN_WORD_OPS = 1'b1
) (
  input  u32              instr,
  output control_t        ctl,
  output creg_addr_t      rs1,
  output creg_addr_t      rs2,
  output creg_addr_t      rd,
  output logic [XLEN-1:0] imm
);
  localparam bit IS64    = (XLEN == 64);
  localparam bit WORD_OK = EN_WORD_OPS && IS64;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  control_t ctl_s;
  imm_sel_t isel;
  logic wr_s, legal_s, shamt_ok;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  // RV32 shift amounts are 5 bits, so shamt[5] must be clear there.
  assign shamt_ok = IS64 || !instr[25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  if (XLEN == 64) begin : g_u64
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'h000};
  end else begin : g_u32
    assign imm_u = {instr[31:12], 12'h000};
  end

  // Opcode/funct decode into a raw bundle plus legality and immediate format.
  always_comb begin
    ctl_s = '0;
    wr_s = 1'b0;
    legal_s = 1'b0;
    isel = IMM_NONE;
    if (instr == 32'h0000_0000) begin
      legal_s = 1'b1;
    end else begin
      case (opc)
        OPC_LUI:   begin legal_s = 1'b1; wr_s = 1'b1; isel = IMM_U; ctl_s.op = OP_LUI; ctl_s.alufunc = ALU_PASSB; end
        OPC_AUIPC: begin legal_s = 1'b1; wr_s = 1'b1; isel = IMM_U; ctl_s.op = OP_AUIPC; end
        OPC_JAL:   begin legal_s = 1'b1; wr_s = 1'b1; isel = IMM_J; ctl_s.op = OP_JAL; ctl_s.is_jump = 1'b1; end
        OPC_JALR: begin
          legal_s = (f3 == 3'b000); wr_s = 1'b1; isel = IMM_I;
          ctl_s.op = OP_JALR; ctl_s.is_jump = 1'b1; ctl_s.use_rs1 = 1'b1;
        end
        OPC_BRANCH: begin
          legal_s = 1'b1; isel = IMM_B;
          ctl_s.is_branch = 1'b1; ctl_s.use_rs1 = 1'b1; ctl_s.use_rs2 = 1'b1;
          case (f3)
            3'b000:  begin ctl_s.op = OP_BEQ;  ctl_s.alufunc = ALU_SUB;  end
            3'b001:  begin ctl_s.op = OP_BNE;  ctl_s.alufunc = ALU_SUB;  end
            3'b100:  begin ctl_s.op = OP_BLT;  ctl_s.alufunc = ALU_SLT;  end
            3'b101:  begin ctl_s.op = OP_BGE;  ctl_s.alufunc = ALU_SLT;  end
            3'b110:  begin ctl_s.op = OP_BLTU; ctl_s.alufunc = ALU_SLTU; end
            3'b111:  begin ctl_s.op = OP_BGEU; ctl_s.alufunc = ALU_SLTU; end
            default: legal_s = 1'b0;
          endcase
        end
        OPC_LOAD: begin
          legal_s = 1'b1; wr_s = 1'b1; isel = IMM_I;
          ctl_s.memread = 1'b1; ctl_s.use_rs1 = 1'b1;
          case (f3)
            3'b000:  begin ctl_s.op = OP_LB;  ctl_s.memsize = MEM_B; end
            3'b001:  begin ctl_s.op = OP_LH;  ctl_s.memsize = MEM_H; end
            3'b010:  begin ctl_s.op = OP_LW;  ctl_s.memsize = MEM_W; end
            3'b011:  begin ctl_s.op = OP_LD;  ctl_s.memsize = MEM_D; legal_s = IS64; end
            3'b100:  begin ctl_s.op = OP_LBU; ctl_s.memsize = MEM_B; ctl_s.memunsigned = 1'b1; end
            3'b101:  begin ctl_s.op = OP_LHU; ctl_s.memsize = MEM_H; ctl_s.memunsigned = 1'b1; end
            3'b110:  begin ctl_s.op = OP_LWU; ctl_s.memsize = MEM_W; ctl_s.memunsigned = 1'b1; legal_s = IS64; end
            default: legal_s = 1'b0;
          endcase
        end
        OPC_STORE: begin
          legal_s = 1'b1; isel = IMM_S;
          ctl_s.memwrite = 1'b1; ctl_s.use_rs1 = 1'b1; ctl_s.use_rs2 = 1'b1;
          case (f3)
            3'b000:  begin ctl_s.op = OP_SB; ctl_s.memsize = MEM_B; end
            3'b001:  begin ctl_s.op = OP_SH; ctl_s.memsize = MEM_H; end
            3'b010:  begin ctl_s.op = OP_SW; ctl_s.memsize = MEM_W; end
            3'b011:  begin ctl_s.op = OP_SD; ctl_s.memsize = MEM_D; legal_s = IS64; end
            default: legal_s = 1'b0;
          endcase
        end
        OPC_OPIMM: begin
          legal_s = 1'b1; wr_s = 1'b1; isel = IMM_I; ctl_s.use_rs1 = 1'b1;
          case (f3)
            F3_ADD_SUB: begin ctl_s.op = OP_ADDI;  ctl_s.alufunc = ALU_ADD;  end
            F3_SLT:     begin ctl_s.op = OP_SLTI;  ctl_s.alufunc = ALU_SLT;  end
            F3_SLTU:    begin ctl_s.op = OP_SLTIU; ctl_s.alufunc = ALU_SLTU; end
            F3_XOR:     begin ctl_s.op = OP_XORI;  ctl_s.alufunc = ALU_XOR;  end
            F3_OR:      begin ctl_s.op = OP_ORI;   ctl_s.alufunc = ALU_OR;   end
            F3_AND:     begin ctl_s.op = OP_ANDI;  ctl_s.alufunc = ALU_AND;  end
            F3_SLL: begin
              ctl_s.op = OP_SLLI; ctl_s.alufunc = ALU_SLL;
              legal_s = (instr[31:26] == 6'b000000) && shamt_ok;
            end
            F3_SRL_SRA: begin
              ctl_s.op = instr[30] ? OP_SRAI : OP_SRLI;
              ctl_s.alufunc = instr[30] ? ALU_SRA : ALU_SRL;
              legal_s = ({instr[31], instr[29:26]} == 5'b00000) && shamt_ok;
            end
            default: legal_s = 1'b0;
          endcase
        end
        OPC_OP: begin
          legal_s = 1'b1; wr_s = 1'b1; ctl_s.use_rs1 = 1'b1; ctl_s.use_rs2 = 1'b1;
          case ({f7, f3})
            {F7_ADD, F3_ADD_SUB}: begin ctl_s.op = OP_ADD;  ctl_s.alufunc = ALU_ADD;  end
            {F7_SUB, F3_ADD_SUB}: begin ctl_s.op = OP_SUB;  ctl_s.alufunc = ALU_SUB;  end
            {F7_ADD, F3_SLL}:     begin ctl_s.op = OP_SLL;  ctl_s.alufunc = ALU_SLL;  end
            {F7_ADD, F3_SLT}:     begin ctl_s.op = OP_SLT;  ctl_s.alufunc = ALU_SLT;  end
            {F7_ADD, F3_SLTU}:    begin ctl_s.op = OP_SLTU; ctl_s.alufunc = ALU_SLTU; end
            {F7_ADD, F3_XOR}:     begin ctl_s.op = OP_XOR;  ctl_s.alufunc = ALU_XOR;  end
            {F7_SRL, F3_SRL_SRA}: begin ctl_s.op = OP_SRL;  ctl_s.alufunc = ALU_SRL;  end
            {F7_SRA, F3_SRL_SRA}: begin ctl_s.op = OP_SRA;  ctl_s.alufunc = ALU_SRA;  end
            {F7_ADD, F3_OR}:      begin ctl_s.op = OP_OR;   ctl_s.alufunc = ALU_OR;   end
            {F7_ADD, F3_AND}:     begin ctl_s.op = OP_AND;  ctl_s.alufunc = ALU_AND;  end
            default:              legal_s = 1'b0;
          endcase
        end
        OPC_OPIMM32: begin
          legal_s = WORD_OK; wr_s = 1'b1; isel = IMM_I;
          ctl_s.use_rs1 = 1'b1; ctl_s.is_word = 1'b1;
          case (f3)
            F3_ADD_SUB: begin ctl_s.op = OP_ADDIW; ctl_s.alufunc = ALU_ADD; end
            F3_SLL: begin
              ctl_s.op = OP_SLLIW; ctl_s.alufunc = ALU_SLL;
              if (f7 != F7_ADD) legal_s = 1'b0;
              else legal_s = WORD_OK;
            end
            F3_SRL_SRA: begin
              ctl_s.op = instr[30] ? OP_SRAIW : OP_SRLIW;
              ctl_s.alufunc = instr[30] ? ALU_SRA : ALU_SRL;
              if ((f7 != F7_SRL) && (f7 != F7_SRA)) legal_s = 1'b0;
              else legal_s = WORD_OK;
            end
            default: legal_s = 1'b0;
          endcase
        end
        OPC_OP32: begin
          legal_s = WORD_OK; wr_s = 1'b1;
          ctl_s.use_rs1 = 1'b1; ctl_s.use_rs2 = 1'b1; ctl_s.is_word = 1'b1;
          case ({f7, f3})
            {F7_ADD, F3_ADD_SUB}: begin ctl_s.op = OP_ADDW; ctl_s.alufunc = ALU_ADD; end
            {F7_SUB, F3_ADD_SUB}: begin ctl_s.op = OP_SUBW; ctl_s.alufunc = ALU_SUB; end
            {F7_ADD, F3_SLL}:     begin ctl_s.op = OP_SLLW; ctl_s.alufunc = ALU_SLL; end
            {F7_SRL, F3_SRL_SRA}: begin ctl_s.op = OP_SRLW; ctl_s.alufunc = ALU_SRL; end
            {F7_SRA, F3_SRL_SRA}: begin ctl_s.op = OP_SRAW; ctl_s.alufunc = ALU_SRA; end
            default:              legal_s = 1'b0;
          endcase
        end
        default: legal_s = 1'b0;
      endcase
    end
  end

  // Final bundle: illegal words collapse to UNKNOWN with no side effects;
  // unused register fields are zeroed so hazard compares never hit them.
  always_comb begin
    ctl = '0;
    rs1 = 5'd0;
    rs2 = 5'd0;
    rd  = 5'd0;
    imm = '0;
    if (legal_s) begin
      ctl = ctl_s;
      ctl.regwrite = wr_s && (instr[11:7] != 5'd0);
      rs1 = ctl_s.use_rs1 ? instr[19:15] : 5'd0;
      rs2 = ctl_s.use_rs2 ? instr[24:20] : 5'd0;
      rd  = wr_s ? instr[11:7] : 5'd0;
      case (isel)
        IMM_I:   imm = imm_i;
        IMM_S:   imm = imm_s;
        IMM_B:   imm = imm_b;
        IMM_U:   imm = imm_u;
        IMM_J:   imm = imm_j;
        default: imm = '0;
      endcase
    end else begin
      ctl.op = OP_UNKNOWN;
      ctl.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with valid/ready handshake.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : fetch-side handshake; in_instr, in_pc carry the word
//   flush                 : drops the held bundle and any same-cycle input
//   out_valid/out_ready   : execute-side handshake
//   out_ctl, out_rs1/rs2/rd, out_imm, out_pc : registered decoded bundle
//   illegal_cnt           : saturating count of delivered illegal bundles
module decode_stage
  import common::*;
  import pipes::*;
#(
  parameter int XLEN        = 64,
  parameter bit EN_WORD_OPS = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  u32               in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output control_t         out_ctl,
  output creg_addr_t       out_rs1,
  output creg_addr_t       out_rs2,
  output creg_addr_t       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);
  control_t dec_ctl;
  creg_addr_t dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic take;

  decode_comb #(.XLEN(XLEN), .EN_WORD_OPS(EN_WORD_OPS)) u_dec (
    .instr (in_instr),
    .ctl   (dec_ctl),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd),
    .imm   (dec_imm)
  );

  // Accept whenever the register is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  // Output register, handshake/flush control and illegal counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_ctl     <= '0;
      out_rs1     <= 5'd0;
      out_rs2     <= 5'd0;
      out_rd      <= 5'd0;
      out_imm     <= '0;
      out_pc      <= '0;
      illegal_cnt <= '0;
    end else begin
      // The delivery handshake still happens on a flush cycle, so it counts.
      if (out_valid && out_ready && out_ctl.illegal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush) begin
        out_valid <= 1'b0;
      end else if (take) begin
        out_valid <= 1'b1;
        out_ctl   <= dec_ctl;
        out_rs1   <= dec_rs1;
        out_rs2   <= dec_rs2;
        out_rd    <= dec_rd;
        out_imm   <= dec_imm;
        out_pc    <= in_pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
